// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: IDLE -> FETCH (read pcValue) -> HOLD (present instrReg) with redirect and fetch timeout.
// Latency: instrReg valid the cycle after memReady; stalls in HOLD until instrAck; redirect overrides everything.
module fetch_ctrl #(
  parameter int N       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [N-1:0] pcValue,
  input  logic [N-1:0] memData,
  input  logic         memReady,
  input  logic         redirect,
  input  logic [N-1:0] redirectAddr,
  input  logic         instrAck,
  output logic [N-1:0] addrBus,
  output logic         readMem,
  output logic         incCnt,
  output logic         iniCnt,
  output logic [N-1:0] initValue,
  output logic [N-1:0] instrReg,
  output logic         instrValid,
  output logic         memErr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Wait count on the TIMEOUT-th consecutive FETCH cycle without memReady.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     nextState;
  logic [7:0] waitCnt;
  logic       accept;
  logic       timeout;

  assign addrBus = pcValue;

  always_comb begin
    nextState  = state;
    readMem    = 1'b0;
    instrValid = 1'b0;
    incCnt     = 1'b0;
    accept     = 1'b0;
    timeout    = 1'b0;
    iniCnt     = redirect & ~rst;
    initValue  = redirect ? redirectAddr : '0;

    case (state)
      IDLE: begin
        if (enable && !memErr) nextState = FETCH;
      end
      FETCH: begin
        readMem = 1'b1;
        if (!redirect) begin
          if (memReady) begin
            accept    = 1'b1;
            incCnt    = 1'b1;
            nextState = HOLD;
          end else if (waitCnt == LAST_WAIT) begin
            timeout   = 1'b1;
            nextState = IDLE;
          end
        end
      end
      HOLD: begin
        instrValid = 1'b1;
        if (instrAck) nextState = enable ? FETCH : IDLE;
      end
      default: nextState = IDLE;
    endcase

    // Redirect wins over memReady and instrAck; a latched error pins the FSM in IDLE.
    if (redirect) nextState = (enable && !memErr) ? FETCH : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= '0;
    end else if (state == FETCH && nextState == FETCH && !redirect) begin
      waitCnt <= waitCnt + 8'd1;
    end else begin
      waitCnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memErr <= 1'b0;
    end else if (timeout) begin
      memErr <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrReg <= '0;
    end else if (accept) begin
      instrReg <= memData;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter N, default 16, SHALL set the width of address, instruction and PC buses.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of FETCH-state cycles without memReady; legal range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 enable  input  1  SHALL permit new fetches when 1.
REQ-006 pcValue  input  N  SHALL be the current PC, taken from the PC counter's data output.
REQ-007 memData  input  N  SHALL be the instruction word returned by memory.
REQ-008 memReady  input  1  SHALL indicate that memData is valid in the current cycle.
REQ-009 redirect  input  1  SHALL request a PC load (branch/jump).
REQ-010 redirectAddr  input  N  SHALL be the PC load target.
REQ-011 instrAck  input  1  SHALL indicate that the decoder has consumed instrReg.
REQ-012 addrBus  output  N  SHALL be the memory read address.
REQ-013 readMem  output  1  SHALL be the memory read strobe.
REQ-014 incCnt  output  1  SHALL drive the PC counter's increment input.
REQ-015 iniCnt  output  1  SHALL drive the PC counter's load input.
REQ-016 initValue  output  N  SHALL drive the PC counter's load value.
REQ-017 instrReg  output  N  SHALL hold the fetched instruction.
REQ-018 instrValid  output  1  SHALL indicate that instrReg holds an unconsumed instruction.
REQ-019 memErr  output  1  SHALL be a sticky fetch-timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, FETCH and HOLD.
REQ-021 IDLE: readMem=0 and instrValid=0; next state SHALL be FETCH if enable=1, else IDLE.
REQ-022 FETCH: readMem=1 and addrBus=pcValue (combinational); addrBus SHALL be pcValue in all other states too.
REQ-023 FETCH with memReady=1 and redirect=0: instrReg SHALL capture memData at the edge, incCnt SHALL be 1 in that same cycle (combinational), and next state SHALL be HOLD.
REQ-024 incCnt SHALL be 1 only under the condition of REQ-023, giving exactly one PC increment per accepted instruction.
REQ-025 HOLD: instrValid=1 and readMem=0; on instrAck=1, next state SHALL be FETCH if enable=1, else IDLE; instrAck SHALL be ignored outside HOLD.
REQ-026 redirect=1 in any state: iniCnt=1 and initValue=redirectAddr (combinational) in that cycle, and next state SHALL be FETCH if enable=1, else IDLE.
REQ-027 Redirect priority: redirect SHALL take precedence over memReady and instrAck. A coincident memReady response SHALL be discarded: instrReg unchanged, incCnt=0. A held instruction SHALL be dropped: instrValid=0 from the next cycle.
REQ-028 initValue SHALL be redirectAddr whenever redirect=1 and SHALL be all zeros otherwise; iniCnt and incCnt SHALL never both be 1.
REQ-029 Wait counter (8 bits) SHALL clear on entry to FETCH and increment each FETCH cycle without memReady.
REQ-030 When the wait count reaches TIMEOUT with memReady=0 and redirect=0, memErr SHALL set and the next state SHALL be IDLE.
REQ-031 While memErr=1, the FSM SHALL remain in IDLE regardless of enable; redirect SHALL still drive iniCnt and initValue, but the state SHALL not leave IDLE.
REQ-032 Dropping enable during FETCH SHALL NOT abort the outstanding read; the FSM SHALL complete to HOLD (or time out).

Reset
REQ-033 rst=1 SHALL immediately force state=IDLE, instrReg=0, instrValid=0, memErr=0, wait counter=0, readMem=0, incCnt=0 and iniCnt=0, independent of clk.
REQ-034 Reset asserted mid-FETCH or mid-HOLD SHALL discard the in-flight or held instruction; the first fetch SHALL occur on the first rising edge after rst deasserts with enable=1.

Verification
REQ-035 Reset, enable=1, pcValue=0x0000, memReady=1 on the second FETCH cycle with memData=0xA5A5 -> one incCnt pulse, instrReg=0xA5A5, instrValid=1 until instrAck.
REQ-036 HOLD with instrAck held 0 for 10 cycles -> instrValid stays 1, readMem=0, no incCnt.
REQ-037 FETCH with redirect=1, redirectAddr=0x0040 and memReady=1 in the same cycle -> iniCnt=1, initValue=0x0040, incCnt=0, instrReg unchanged, next state FETCH.
REQ-038 TIMEOUT=4, memReady never asserted -> memErr=1 after 4 FETCH cycles; FSM stays in IDLE with enable=1 until rst.
REQ-039 rst pulsed asynchronously (between edges) during HOLD -> instrValid=0 and memErr=0 immediately; the fetch sequence restarts after release.
REQ-040 Closed loop with the PC counter, 5 fetches from 0x0010 -> addrBus sequence 0x0010..0x0014, and the PC counter's carry-out stays 0.
